temp_sensor_reader: RTL and testbench
=====================================

Name: temp_sensor_reader

Overview:
- Periodic read sequencer between the I2C master and the 7-segment display driver in the temperature-sensor design.
- Every sample period it commands the I2C master to do a 2-byte read from the temperature sensor (LM75/TMP102-style register 0).
- Converts the signed integer byte to sign plus 3 BCD digits, with a 0.5 °C flag, and presents them to the display stage with a valid strobe.

Parameters:
- SENSOR_ADDR, 7'h48, 7-bit I2C slave address driven on i2c_addr.
- SAMPLE_DIV, 25000000, clk cycles between read starts (0.5 s at 50 MHz); minimum 64.
- TIMEOUT_CYC, 100000, max cycles waiting for any busy edge before declaring an error.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i2c_ena  out  1  request/continue transaction to I2C master
- i2c_addr  out  7  slave address (constant SENSOR_ADDR)
- i2c_rw  out  1  1=read (held 1 whenever i2c_ena=1)
- i2c_busy  in  1  master busy; rises when a byte is accepted, falls when it completes
- i2c_data_rd  in  8  byte read; valid on busy falling edge
- i2c_ack_err  in  1  NACK flag from master
- temp_raw  out  16  {MSB,LSB} of last good read
- neg  out  1  temperature negative
- bcd_hund, bcd_tens, bcd_ones  out  4 each  magnitude digits
- half  out  1  LSB[7] (+0.5 °C)
- valid  out  1  one-cycle pulse when outputs update
- err  out  1  last attempt failed (sticky until next good read)

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM=WAIT, period counter=0, busy_q=0. Reset mid-transaction drops i2c_ena in the same instant.
- i2c_addr is SENSOR_ADDR and i2c_rw is 1 at all times, including during reset.
- Edge detect: busy_q registers i2c_busy. rise = busy & ~busy_q; fall = ~busy & busy_q.
- WAIT: period counter counts 0..SAMPLE_DIV-1. At terminal count the counter clears and the FSM goes to REQ. First read starts SAMPLE_DIV cycles after reset release.
- REQ: i2c_ena=1.
  - On rise: go BYTE1; ena stays 1 so the master chains the second byte.
- BYTE1: on fall, capture i2c_data_rd into msb_q and go CHAIN.
- CHAIN: on rise (second byte accepted), drop i2c_ena to 0 and go BYTE2.
- BYTE2: on fall, capture lsb_q and go CONV.
- Error exit: in any of REQ/BYTE1/CHAIN/BYTE2, a fall with i2c_ack_err=1, or TIMEOUT_CYC cycles with no rise/fall:
  - i2c_ena=0, err=1, valid not pulsed, data outputs held, go WAIT.
  - Timeout counter resets on every state entry and every busy edge.
- CONV:
  - Magnitude m = msb_q[7] ? (~msb_q+1) : msb_q. Treat as 8-bit unsigned; 0x80 gives 128.
  - Sequential double-dabble, one shift per cycle, 8 cycles: add 3 to any digit ≥5, then shift.
  - Then one cycle DONE: register digits, neg=msb_q[7], half=lsb_q[7], temp_raw={msb_q,lsb_q}, err=0, valid=1 for exactly 1 cycle, go WAIT.
- Latency: second-byte busy fall → valid high = 10 clk.
- Period counter runs in every state, so the sample rate is fixed.
  - A terminal count outside WAIT is ignored; the transaction completes and the next read waits for the next terminal count.
- Outputs change only in DONE, the error exit (err only), or reset.

Test Plan:
- I2C master BFM returns MSB 0x19, LSB 0x80 → exactly one valid pulse; neg=0, digits 0/2/5, half=1, temp_raw=0x1980, err=0; valid 10 clk after second busy fall; i2c_ena low after second busy rise.
- MSB 0xE7, LSB 0x00 → neg=1, digits 0/2/5, half=0. MSB 0x80 → neg=1, digits 1/2/8. MSB 0x7F → neg=0, digits 1/2/7.
- ack_err=1 on first busy fall → err=1, i2c_ena=0 next cycle, no valid, previous digits held. Next period with a good read → err=0, valid pulses.
- BFM never raises busy, TIMEOUT_CYC=50 → err=1 and i2c_ena=0 exactly 50 cycles after i2c_ena rose.
- reset_n low during BYTE1 → i2c_ena, valid, err and digits 0 immediately. After release, the first i2c_ena comes SAMPLE_DIV cycles later.
- Back-to-back periods with SAMPLE_DIV=64: i2c_ena rising edges are exactly 64 cycles apart, and 2 reads produce 2 valid pulses.

Source files
------------

// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader: periodic 2-byte temperature read over the I2C master,
// converted to sign, three BCD digits and a half-degree flag for the display.
module temp_sensor_reader #(
    parameter logic [6:0] SENSOR_ADDR = 7'h48,
    parameter int         SAMPLE_DIV  = 25000000,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        i2c_ena,
    output logic [6:0]  i2c_addr,
    output logic        i2c_rw,
    input  logic        i2c_busy,
    input  logic [7:0]  i2c_data_rd,
    input  logic        i2c_ack_err,
    output logic [15:0] temp_raw,
    output logic        neg,
    output logic [3:0]  bcd_hund,
    output logic [3:0]  bcd_tens,
    output logic [3:0]  bcd_ones,
    output logic        half,
    output logic        valid,
    output logic        err
);
    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_WAIT, S_REQ, S_BYTE1, S_CHAIN, S_BYTE2, S_CONV, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  per_q, per_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           busy_q;
    logic [7:0]     msb_q, msb_d, lsb_q, lsb_d, bin_q, bin_d;
    logic [11:0]    bcd_q, bcd_d, adj;
    logic [2:0]     sh_q, sh_d;
    logic [15:0]    raw_q, raw_d;
    logic           neg_q, neg_d, half_q, half_d, valid_q, valid_d, err_q, err_d;
    logic [3:0]     hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic           rise, fall, tc, timeout, active, abort;

    function automatic logic [3:0] dab(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_comb begin
        rise    = i2c_busy & ~busy_q;
        fall    = ~i2c_busy & busy_q;
        tc      = per_q == PW'(SAMPLE_DIV - 1);
        per_d   = tc ? '0 : per_q + 1'b1;
        timeout = tmo_q == TW'(TIMEOUT_CYC - 1);
        active  = state_q inside {S_REQ, S_BYTE1, S_CHAIN, S_BYTE2};
        abort   = active && ((fall && i2c_ack_err) || timeout);
        adj     = {dab(bcd_q[11:8]), dab(bcd_q[7:4]), dab(bcd_q[3:0])};
        state_d = state_q;
        msb_d   = msb_q;
        lsb_d   = lsb_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        sh_d    = sh_q;
        raw_d   = raw_q;
        neg_d   = neg_q;
        half_d  = half_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        err_d   = err_q;
        valid_d = 1'b0;
        if (abort) begin
            state_d = S_WAIT;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_WAIT:  state_d = tc ? S_REQ : S_WAIT;
                S_REQ:   state_d = rise ? S_BYTE1 : S_REQ;
                S_BYTE1: begin
                    msb_d   = fall ? i2c_data_rd : msb_q;
                    state_d = fall ? S_CHAIN : S_BYTE1;
                end
                S_CHAIN: state_d = rise ? S_BYTE2 : S_CHAIN;
                S_BYTE2: if (fall) begin
                    lsb_d   = i2c_data_rd;
                    bin_d   = msb_q[7] ? ~msb_q + 8'd1 : msb_q;
                    bcd_d   = '0;
                    sh_d    = '0;
                    state_d = S_CONV;
                end
                S_CONV: begin
                    {bcd_d, bin_d} = {adj, bin_q} << 1;
                    sh_d    = sh_q + 3'd1;
                    state_d = (sh_q == 3'd7) ? S_DONE : S_CONV;
                end
                S_DONE: begin
                    hund_d  = bcd_q[11:8];
                    tens_d  = bcd_q[7:4];
                    ones_d  = bcd_q[3:0];
                    neg_d   = msb_q[7];
                    half_d  = lsb_q[7];
                    raw_d   = {msb_q, lsb_q};
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_WAIT;
                end
                default: state_d = S_WAIT;
            endcase
        end
        // Timeout window restarts on every state entry and every busy edge
        tmo_d = (state_d != state_q || rise || fall) ? '0 : tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            per_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            msb_q   <= '0;
            lsb_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            sh_q    <= '0;
            raw_q   <= '0;
            neg_q   <= 1'b0;
            half_q  <= 1'b0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            tmo_q   <= tmo_d;
            busy_q  <= i2c_busy;
            msb_q   <= msb_d;
            lsb_q   <= lsb_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            sh_q    <= sh_d;
            raw_q   <= raw_d;
            neg_q   <= neg_d;
            half_q  <= half_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign i2c_ena  = state_q inside {S_REQ, S_BYTE1, S_CHAIN};
    assign i2c_addr = SENSOR_ADDR;
    assign i2c_rw   = 1'b1;
    assign temp_raw = raw_q;
    assign neg      = neg_q;
    assign bcd_hund = hund_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign half     = half_q;
    assign valid    = valid_q;
    assign err      = err_q;
endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb_temp_sensor_reader: directed and random reads through an I2C master BFM,
// checked against an arithmetic reference of the expected display values.
module tb_temp_sensor_reader;
    localparam int SD = 64;
    localparam int TO = 50;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        i2c_busy = 1'b0, i2c_ack_err = 1'b0;
    logic [7:0]  i2c_data_rd = 8'h00;
    logic        i2c_ena, i2c_rw, neg, half, valid, err;
    logic [6:0]  i2c_addr;
    logic [15:0] temp_raw;
    logic [3:0]  bcd_hund, bcd_tens, bcd_ones;

    temp_sensor_reader #(.SENSOR_ADDR(7'h48), .SAMPLE_DIV(SD), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .i2c_ena(i2c_ena), .i2c_addr(i2c_addr),
        .i2c_rw(i2c_rw), .i2c_busy(i2c_busy), .i2c_data_rd(i2c_data_rd),
        .i2c_ack_err(i2c_ack_err), .temp_raw(temp_raw), .neg(neg),
        .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
        .half(half), .valid(valid), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int vcnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (valid) vcnt <= vcnt + 1;

    int ncmp = 0, nbad = 0;
    int ref_rise = 0;
    logic [15:0] e_raw = '0;
    logic        e_neg = 0, e_half = 0, e_err = 0;
    logic [3:0]  e_h = '0, e_t = '0, e_o = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: two's-complement magnitude split into decimal digits
    task automatic model(input logic [7:0] msb, input logic [7:0] lsb);
        int m;
        m      = msb[7] ? 256 - int'(msb) : int'(msb);
        e_h    = 4'(m / 100);
        e_t    = 4'((m / 10) % 10);
        e_o    = 4'(m % 10);
        e_neg  = msb[7];
        e_half = lsb[7];
        e_raw  = {msb, lsb};
        e_err  = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_raw"}, temp_raw, e_raw);
        check({tag, "_digits"}, {neg, bcd_hund, bcd_tens, bcd_ones, half}, {e_neg, e_h, e_t, e_o, e_half});
        check({tag, "_err"}, err, e_err);
    endtask

    task automatic wait_ena(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            ok = i2c_ena;
        end
        if (!ok) check("ena_never_rose", 0, 1);
        else begin
            check("ena_period", cyc - ref_rise, SD);
            ref_rise = cyc;
        end
    endtask

    task automatic good_read(input logic [7:0] msb, input logic [7:0] lsb, input string tag);
        bit ok, seen;
        int v0, pfall;
        wait_ena(ok);
        if (!ok) return;
        v0 = vcnt;
        tick();
        i2c_busy = 1;
        repeat (3) tick();
        i2c_data_rd = msb;
        i2c_busy = 0;
        repeat (2) tick();
        check({tag, "_ena_chain"}, i2c_ena, 1);
        i2c_busy = 1;
        tick();
        check({tag, "_ena_drop"}, i2c_ena, 0);
        repeat (2) tick();
        i2c_data_rd = lsb;
        i2c_busy = 0;
        pfall = cyc;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = valid;
        end
        check({tag, "_latency"}, seen ? cyc - pfall : -1, 10);
        model(msb, lsb);
        check_outs(tag);
        tick();
        check({tag, "_one_valid"}, {vcnt - v0, 31'(valid)}, {32'd1, 31'd0});
    endtask

    initial begin
        bit ok;
        int v0, n;
        logic [7:0] rm, rl;
        repeat (3) tick();
        check("rst_ena_valid", {i2c_ena, valid}, 2'b00);
        check("rst_addr_rw", {i2c_addr, i2c_rw}, {7'h48, 1'b1});
        check_outs("rst");
        reset_n = 1;
        ref_rise = cyc;

        good_read(8'h19, 8'h80, "r19");
        good_read(8'hE7, 8'h00, "rE7");
        good_read(8'h80, 8'($urandom_range(0, 255)), "r80");
        good_read(8'h7F, 8'($urandom_range(0, 255)), "r7F");

        // NACK on the first byte: error, no valid, previous digits held
        wait_ena(ok);
        if (ok) begin
            v0 = vcnt;
            tick();
            i2c_busy = 1;
            repeat (3) tick();
            i2c_data_rd = 8'h55;
            i2c_ack_err = 1;
            i2c_busy = 0;
            tick();
            i2c_ack_err = 0;
            e_err = 1;
            check("nack_ena", i2c_ena, 0);
            check_outs("nack");
            repeat (20) tick();
            check("nack_no_valid", vcnt - v0, 0);
        end
        good_read(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)), "recover");

        // Busy never rises: timeout after TO cycles of enable
        wait_ena(ok);
        if (ok) begin
            v0 = vcnt;
            n = 0;
            for (int i = 0; i < 80 && i2c_ena; i++) begin
                tick();
                n++;
            end
            e_err = 1;
            check("tmo_cycles", n, TO);
            check_outs("tmo");
            check("tmo_no_valid", vcnt - v0, 0);
        end

        // Reset while in the first byte clears everything at once
        wait_ena(ok);
        if (ok) begin
            tick();
            i2c_busy = 1;
            repeat (2) tick();
            reset_n = 0;
            i2c_busy = 0;
            #1;
            check("mid_rst_ena_valid", {i2c_ena, valid}, 2'b00);
            model(8'h00, 8'h00);
            check_outs("mid_rst");
            repeat (3) tick();
            reset_n = 1;
            ref_rise = cyc;
        end

        for (int k = 0; k < 6; k++) begin
            rm = 8'($urandom_range(0, 255));
            rl = 8'($urandom_range(0, 255));
            good_read(rm, rl, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
